pixel_scheduler: RTL
====================

PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameter NUM_SOLVERS, default 4, meaning the number of solver lanes it schedules (1..8).
REQ-002 SHALL have parameter IDX_W, default 20, meaning the width of the pixel-index counter.
REQ-003 SHALL have port clock, input, 1, the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle frame-start pulse, honoured only in IDLE or DONE.
REQ-006 SHALL have ports min_x, min_y, max_x, max_y, dx, dy, input, 27 each, signed fixed-point frame bounds and steps, sampled on accepted start.
REQ-007 SHALL have port sol_flush, output, 1, clear pulse to all solver lanes.
REQ-008 SHALL have port sol_start, output, NUM_SOLVERS, one-hot load strobe selecting the lane that takes sol_c_re/sol_c_im.
REQ-009 SHALL have ports sol_c_re, sol_c_im, output, 27 each, coordinate bus shared by all lanes.
REQ-010 SHALL have port sol_ready, input, NUM_SOLVERS, per-lane result-valid pulse.
REQ-011 SHALL have port sol_out, input, 4*NUM_SOLVERS, per-lane 4-bit colour; lane i at bits [4i+3:4i].
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_color (output, 4) and out_index (output, IDX_W) forming the result stream.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1) for frame status.

Function
REQ-014 SHALL implement FSM IDLE -> DISPATCH on accepted start; DISPATCH -> DRAIN when the last coordinate issues; DRAIN -> DONE when no lane is busy and no result is held; DONE -> DISPATCH on start.
REQ-015 SHALL, on accepted start, pulse sol_flush for one cycle, load x=min_x, y=min_y and idx=0, and clear all lane-busy and lane-held flags.
REQ-016 SHALL issue at most one coordinate per cycle in DISPATCH, to the lowest-index lane that is neither busy nor holding a result; first sol_start occurs the cycle after start.
REQ-017 SHALL walk raster order: x+=dx while x+dx<max_x; otherwise x=min_x, y+=dy; the frame ends when the next y is >= max_y; comparisons are signed 27-bit.
REQ-018 SHALL record idx per lane at issue and increment idx by one per issued coordinate, wrapping modulo 2^IDX_W.
REQ-019 SHALL latch sol_out into the lane's hold register on sol_ready and set held; sol_ready on a non-busy lane SHALL be ignored.
REQ-020 SHALL select one held lane into a registered output slot; out_valid is asserted the cycle after sol_ready at the earliest.
REQ-021 SHALL keep out_color and out_index stable while out_valid is high and out_ready is low.
REQ-022 SHALL free a lane (busy=0, held=0) only on the out_valid&&out_ready cycle for its result; a freed lane may be re-issued that same cycle.
REQ-023 SHALL, for an empty frame (min_x>=max_x or min_y>=max_y), issue nothing and reach DONE two cycles after start.
REQ-024 SHALL ignore start in DISPATCH and DRAIN.
REQ-025 SHALL hold busy=1 in DISPATCH and DRAIN, and done=1 in DONE until the next start or reset.

Reset
REQ-026 SHALL on reset enter IDLE, clear all lane flags, set idx=0, and drive sol_start=0, sol_flush=1, out_valid=0, out_color=0, out_index=0, busy=0 and done=0.
REQ-027 SHALL, on reset mid-frame, discard all held results and in-flight lanes without emitting them.

Configuration
REQ-028 SHALL, with PIXEL_SCHED_RR_EN defined, pick the output lane round-robin, starting at the lane after the last granted lane.
REQ-029 SHALL, without PIXEL_SCHED_RR_EN, pick the output lane by fixed priority, lowest index first.

Verification
REQ-030 Frame 4x2 (min 0, max 4/2, dx=dy=1), NUM_SOLVERS=4, solvers respond in 3 cycles, out_ready=1 -> exactly 8 outputs, indices 0..7 each once, then done=1.
REQ-031 min_x=max_x=5 -> no sol_start, no out_valid, and done=1 two cycles after start.
REQ-032 out_ready=0 for 20 cycles with all 4 lanes held -> no further sol_start, out_color/out_index stable, no result lost after release.
REQ-033 Lanes 0..3 raise sol_ready in the same cycle -> RR build grants 0,1,2,3 and fixed build grants 0,1,2,3, then lane 0 re-issues first; after re-issue with lanes 1 and 3 held, RR build grants 1 then 3.
REQ-034 reset at the 3rd output mid-frame, then a new start -> no stale out_valid, idx restarts at 0, and sol_flush pulses.
REQ-035 start pulsed during DISPATCH -> ignored, and the frame completes with the original 8 indices.

Source files
------------

// File: rtl/pixel_scheduler.sv
// rtl/pixel_scheduler.sv - raster pixel dispatcher for a bank of solver lanes
// Purpose: walks a signed fixed-point frame in raster order, hands each coordinate
//    to the lowest free solver lane, collects per-lane colours and emits them as an
//    index-tagged result stream.
// Build option: PIXEL_SCHED_RR_EN selects round-robin result arbitration; without
//    it the lowest held lane wins.
// Ports:
//    clock, reset                           - clock, synchronous active-high reset
//    start                                  - frame start pulse (accepted in IDLE/DONE)
//    min_x, min_y, max_x, max_y, dx, dy     - signed 27-bit frame bounds and steps
//    sol_flush                              - clear pulse to all lanes
//    sol_start                              - one-hot lane load strobe
//    sol_c_re, sol_c_im                     - coordinate bus shared by all lanes
//    sol_ready, sol_out                     - per-lane result pulse and 4-bit colour
//    out_valid, out_ready, out_color, out_index - result stream
//    busy, done                             - frame status
module pixel_scheduler #(
   parameter int NUM_SOLVERS = 4,
   parameter int IDX_W       = 20
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [26:0]              min_x,
   input  logic [26:0]              min_y,
   input  logic [26:0]              max_x,
   input  logic [26:0]              max_y,
   input  logic [26:0]              dx,
   input  logic [26:0]              dy,
   output logic                     sol_flush,
   output logic [NUM_SOLVERS-1:0]   sol_start,
   output logic [26:0]              sol_c_re,
   output logic [26:0]              sol_c_im,
   input  logic [NUM_SOLVERS-1:0]   sol_ready,
   input  logic [4*NUM_SOLVERS-1:0] sol_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_color,
   output logic [IDX_W-1:0]         out_index,
   output logic                     busy,
   output logic                     done
);
   localparam int LW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
   state_t state_q, state_d;

   logic signed [26:0] x_q, x_d, y_q, y_d;
   logic signed [26:0] min_x_q, max_x_q, max_y_q, dx_q, dy_q;
   logic signed [26:0] x_next, y_next;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic [NUM_SOLVERS-1:0] lane_busy_q, lane_busy_d, lane_held_q, lane_held_d;
   logic [3:0]             hold_color_q [NUM_SOLVERS];
   logic [3:0]             hold_color_d [NUM_SOLVERS];
   logic [IDX_W-1:0]       lane_idx_q [NUM_SOLVERS];
   logic [IDX_W-1:0]       lane_idx_d [NUM_SOLVERS];

   logic             out_valid_q, out_valid_d;
   logic [3:0]       out_color_q, out_color_d;
   logic [IDX_W-1:0] out_index_q, out_index_d;
   logic [LW-1:0]    out_lane_q, out_lane_d;
   logic             flush_q;

`ifdef PIXEL_SCHED_RR_EN
   logic [LW-1:0] last_grant_q, last_grant_d;
   int            rr_j;
`endif

   logic                   start_acc, handshake, coord_ok, issue_found, issue_en;
   logic                   slot_load, grant_en;
   logic [NUM_SOLVERS-1:0] lane_free, pend;
   logic [LW-1:0]          issue_lane, grant_lane;

   assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
   assign handshake = out_valid_q && out_ready;
   assign x_next    = x_q + dx_q;
   assign y_next    = y_q + dy_q;
   // Only false on the first cycle of an empty frame; afterwards the walk stays in bounds.
   assign coord_ok  = (x_q < max_x_q) && (y_q < max_y_q);
   assign slot_load = !out_valid_q || handshake;

   // Lane selection for issue and for the output slot.
   always_comb begin
      lane_free = ~lane_busy_q;
      // The lane whose result leaves this cycle can take a new coordinate immediately.
      if (handshake) lane_free[out_lane_q] = 1'b1;
      issue_lane  = '0;
      issue_found = 1'b0;
      for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
         if (lane_free[i]) begin
            issue_lane  = LW'(i);
            issue_found = 1'b1;
         end
      end
      issue_en = (state_q == S_DISPATCH) && coord_ok && issue_found;

      // Held results not already sitting in the output slot.
      pend = lane_held_q;
      if (out_valid_q) pend[out_lane_q] = 1'b0;
      grant_en   = slot_load && (|pend);
      grant_lane = '0;
`ifdef PIXEL_SCHED_RR_EN
      rr_j = 0;
      // Search downward so the lane right after the last grant wins.
      for (int k = NUM_SOLVERS; k >= 1; k--) begin
         rr_j = (int'(last_grant_q) + k) % NUM_SOLVERS;
         if (pend[rr_j]) grant_lane = LW'(rr_j);
      end
`else
      for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
         if (pend[i]) grant_lane = LW'(i);
      end
`endif
   end

   // Frame FSM and raster walk.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DISPATCH;
               x_d     = min_x;
               y_d     = min_y;
               idx_d   = '0;
            end
         end
         S_DISPATCH: begin
            if (!coord_ok) begin
               state_d = (|lane_busy_q) ? S_DRAIN : S_DONE;
            end else if (issue_en) begin
               idx_d = idx_q + 1'b1;
               if (x_next < max_x_q) begin
                  x_d = x_next;
               end else begin
                  x_d = min_x_q;
                  y_d = y_next;
                  if (y_next >= max_y_q) state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (~|(lane_busy_q | lane_held_q)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lane bookkeeping and the registered output slot.
   always_comb begin
      lane_busy_d  = lane_busy_q;
      lane_held_d  = lane_held_q;
      hold_color_d = hold_color_q;
      lane_idx_d   = lane_idx_q;
      out_valid_d  = out_valid_q;
      out_color_d  = out_color_q;
      out_index_d  = out_index_q;
      out_lane_d   = out_lane_q;
`ifdef PIXEL_SCHED_RR_EN
      last_grant_d = last_grant_q;
`endif
      if (start_acc) begin
         lane_busy_d = '0;
         lane_held_d = '0;
      end else begin
         for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (sol_ready[i] && lane_busy_q[i] && !lane_held_q[i]) begin
               lane_held_d[i]  = 1'b1;
               hold_color_d[i] = sol_out[4*i +: 4];
            end
         end
         if (handshake) begin
            lane_busy_d[out_lane_q] = 1'b0;
            lane_held_d[out_lane_q] = 1'b0;
         end
         if (issue_en) begin
            lane_busy_d[issue_lane] = 1'b1;
            lane_idx_d[issue_lane]  = idx_q;
         end
      end
      if (slot_load) begin
         out_valid_d = grant_en;
         if (grant_en) begin
            out_color_d  = hold_color_q[grant_lane];
            out_index_d  = lane_idx_q[grant_lane];
            out_lane_d   = grant_lane;
`ifdef PIXEL_SCHED_RR_EN
            last_grant_d = grant_lane;
`endif
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         lane_busy_q <= '0;
         lane_held_q <= '0;
         out_valid_q <= 1'b0;
         out_color_q <= '0;
         out_index_q <= '0;
         out_lane_q  <= '0;
         flush_q     <= 1'b1;
`ifdef PIXEL_SCHED_RR_EN
         last_grant_q <= LW'(NUM_SOLVERS - 1);
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lane_busy_q <= lane_busy_d;
         lane_held_q <= lane_held_d;
         out_valid_q <= out_valid_d;
         out_color_q <= out_color_d;
         out_index_q <= out_index_d;
         out_lane_q  <= out_lane_d;
         flush_q     <= start_acc;
`ifdef PIXEL_SCHED_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Datapath registers: contents only matter while the matching flags are set.
   always_ff @(posedge clock) begin
      x_q          <= x_d;
      y_q          <= y_d;
      hold_color_q <= hold_color_d;
      lane_idx_q   <= lane_idx_d;
      if (start_acc) begin
         min_x_q <= min_x;
         max_x_q <= max_x;
         max_y_q <= max_y;
         dx_q    <= dx;
         dy_q    <= dy;
      end
   end

   assign sol_flush = flush_q;
   assign sol_start = issue_en ? (NUM_SOLVERS'(1) << issue_lane) : '0;
   assign sol_c_re  = x_q;
   assign sol_c_im  = y_q;
   assign out_valid = out_valid_q;
   assign out_color = out_color_q;
   assign out_index = out_index_q;
   assign busy      = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
endmodule
